// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator.
// o_tick fires every div_int (+1 when the fractional accumulator carries)
// cycles; o_bit_tick fires on every OVERSAMPLE-th o_tick. New divisors are
// staged in a pending copy and take effect on a period boundary, or right
// away while the generator is disabled.
// Optional feature: define BAUD_GEN_FRAC_EN to build the fractional
// accumulator. Without it the period is exactly div_int and i_div_frac is
// ignored.
module baud_gen_frac #(
  parameter int NB_COUNTER       = 12,
  parameter int NB_FRAC          = 8,
  parameter int OVERSAMPLE       = 16,
  parameter int DEFAULT_DIV_INT  = 162,
  parameter int DEFAULT_DIV_FRAC = 195
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_enable,
  input  logic [NB_COUNTER-1:0] i_div_int,
  input  logic [NB_FRAC-1:0]    i_div_frac,
  input  logic                  i_div_load,
  output logic                  o_load_ack,
  output logic                  o_tick,
  output logic                  o_bit_tick
);

  localparam int NB_OS = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [NB_OS-1:0] OS_LAST = NB_OS'(OVERSAMPLE - 1);

  logic                  rst_dly_q;
  logic [NB_COUNTER-1:0] div_int_q, div_int_d;
  logic [NB_COUNTER-1:0] pend_int_q, pend_int_d;
  logic [NB_COUNTER-1:0] counter_q, counter_d;
  logic                  pend_q, pend_d;
  logic [NB_OS-1:0]      os_q, os_d;
  logic [NB_COUNTER-1:0] in_int_clamped;
  logic [NB_COUNTER-1:0] load_int;
  logic [NB_COUNTER-1:0] tc;
  logic                  extra;
  logic                  out_en;
  logic                  apply;

`ifdef BAUD_GEN_FRAC_EN
  logic [NB_FRAC-1:0] div_frac_q, div_frac_d;
  logic [NB_FRAC-1:0] pend_frac_q, pend_frac_d;
  logic [NB_FRAC-1:0] acc_q, acc_d;
  logic [NB_FRAC-1:0] load_frac;
  logic [NB_FRAC-1:0] frac_sel;
  logic [NB_FRAC:0]   acc_sum;
  logic               extra_q, extra_d;

  assign extra     = extra_q;
  assign load_frac = i_div_load ? i_div_frac : pend_frac_q;
  // A divisor applied on a tick also drives the accumulation at that tick,
  // so the very next period already follows the new ratio.
  assign frac_sel  = apply ? load_frac : div_frac_q;
  assign acc_sum   = {1'b0, acc_q} + {1'b0, frac_sel};
`else
  logic unused_frac;

  assign extra       = 1'b0;
  assign unused_frac = ^{i_div_frac, NB_FRAC'(DEFAULT_DIV_FRAC)};
`endif

  // A divisor below 2 would make the terminal count unreachable or zero-length.
  assign in_int_clamped = (i_div_int < NB_COUNTER'(2)) ? NB_COUNTER'(2) : i_div_int;
  assign load_int       = i_div_load ? in_int_clamped : pend_int_q;
  assign tc             = div_int_q - NB_COUNTER'(1) + {{(NB_COUNTER-1){1'b0}}, extra};

  // Outputs stay quiet while reset is asserted and for one cycle after it.
  assign out_en     = i_reset_n & ~rst_dly_q;
  assign o_tick     = out_en & i_enable & (counter_q == tc);
  assign o_bit_tick = o_tick & (os_q == OS_LAST);
  assign apply      = out_en & (pend_q | i_div_load) & (o_tick | ~i_enable);
  assign o_load_ack = apply;

  // Next-state: divisor staging/apply, period counter, oversample counter.
  always_comb begin
    div_int_d  = div_int_q;
    pend_int_d = pend_int_q;
    pend_d     = pend_q;
    counter_d  = counter_q;
    os_d       = os_q;
`ifdef BAUD_GEN_FRAC_EN
    div_frac_d  = div_frac_q;
    pend_frac_d = pend_frac_q;
    acc_d       = acc_q;
    extra_d     = extra_q;
`endif

    if (i_div_load) begin
      pend_int_d = in_int_clamped;
      pend_d     = 1'b1;
`ifdef BAUD_GEN_FRAC_EN
      pend_frac_d = i_div_frac;
`endif
    end

    if (apply) begin
      div_int_d = load_int;
      pend_d    = 1'b0;
`ifdef BAUD_GEN_FRAC_EN
      div_frac_d = load_frac;
`endif
    end

    if (!i_enable) begin
      counter_d = '0;
      os_d      = '0;
`ifdef BAUD_GEN_FRAC_EN
      acc_d   = '0;
      extra_d = 1'b0;
`endif
    end else if (o_tick) begin
      counter_d = '0;
      os_d      = (os_q == OS_LAST) ? '0 : os_q + NB_OS'(1);
`ifdef BAUD_GEN_FRAC_EN
      acc_d   = acc_sum[NB_FRAC-1:0];
      extra_d = acc_sum[NB_FRAC];
`endif
    end else begin
      counter_d = counter_q + NB_COUNTER'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rst_dly_q  <= 1'b1;
      div_int_q  <= NB_COUNTER'(DEFAULT_DIV_INT);
      pend_int_q <= '0;
      pend_q     <= 1'b0;
      counter_q  <= '0;
      os_q       <= '0;
`ifdef BAUD_GEN_FRAC_EN
      div_frac_q  <= NB_FRAC'(DEFAULT_DIV_FRAC);
      pend_frac_q <= '0;
      acc_q       <= '0;
      extra_q     <= 1'b0;
`endif
    end else begin
      rst_dly_q  <= 1'b0;
      div_int_q  <= div_int_d;
      pend_int_q <= pend_int_d;
      pend_q     <= pend_d;
      counter_q  <= counter_d;
      os_q       <= os_d;
`ifdef BAUD_GEN_FRAC_EN
      div_frac_q  <= div_frac_d;
      pend_frac_q <= pend_frac_d;
      acc_q       <= acc_d;
      extra_q     <= extra_d;
`endif
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac. Stimulus pushes the hand-computed cycle
// numbers of expected ticks and acks into queues; a negedge monitor pops and
// compares them whenever the DUT asserts an output.
module tb_baud_gen_frac;

  logic        clk = 1'b0;
  logic        i_reset_n;
  logic        i_enable;
  logic [11:0] i_div_int;
  logic [7:0]  i_div_frac;
  logic        i_div_load;
  logic        o_load_ack;
  logic        o_tick;
  logic        o_bit_tick;

  always #5 clk = ~clk;

  baud_gen_frac dut (
    .i_clk      (clk),
    .i_reset_n  (i_reset_n),
    .i_enable   (i_enable),
    .i_div_int  (i_div_int),
    .i_div_frac (i_div_frac),
    .i_div_load (i_div_load),
    .o_load_ack (o_load_ack),
    .o_tick     (o_tick),
    .o_bit_tick (o_bit_tick)
  );

  typedef struct {
    int c;
    bit b;
  } tick_t;

  tick_t tq[$];
  int    aq[$];
  tick_t mon_e;
  int    mon_a;
  int    cyc      = 0;
  int    checks   = 0;
  int    fails    = 0;
  int    tick_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // cycle watchdog
  always @(posedge clk) begin
    if (cyc > 20000) begin
      $display("FAIL watchdog: cycle %0d exceeds budget 20000", cyc);
      $fatal(1, "watchdog expired");
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    while (tq.size() > 0 && tq[0].c < cyc) begin
      checks++; fails++;
      $display("FAIL missing_tick: got no tick, required tick at cycle %0d", tq[0].c);
      void'(tq.pop_front());
    end
    while (aq.size() > 0 && aq[0] < cyc) begin
      checks++; fails++;
      $display("FAIL missing_ack: got no ack, required ack at cycle %0d", aq[0]);
      void'(aq.pop_front());
    end
    if (o_tick) begin
      tick_cnt++;
      checks++;
      if (tq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_tick: tick at cycle %0d, required none", cyc);
      end else begin
        mon_e = tq.pop_front();
        if (mon_e.c != cyc || mon_e.b != o_bit_tick) begin
          fails++;
          $display("FAIL tick: got cycle %0d bit %0b, required cycle %0d bit %0b",
                   cyc, o_bit_tick, mon_e.c, mon_e.b);
        end
      end
    end else if (o_bit_tick) begin
      checks++; fails++;
      $display("FAIL bit_without_tick: o_bit_tick=1 at cycle %0d, required 0", cyc);
    end
    if (o_load_ack) begin
      checks++;
      if (aq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ack: ack at cycle %0d, required none", cyc);
      end else begin
        mon_a = aq.pop_front();
        if (mon_a != cyc) begin
          fails++;
          $display("FAIL ack: got cycle %0d, required cycle %0d", cyc, mon_a);
        end
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_tick(input int c, input int idx);
    tq.push_back('{c: c, b: ((idx % 16) == 15)});
  endtask

  task automatic do_load(input int di, input int df);
    i_div_int  = 12'(di);
    i_div_frac = 8'(df);
    i_div_load = 1'b1;
    @(posedge clk);
    #1;
    i_div_load = 1'b0;
  endtask

  // enable with counters cleared; expect n ticks of period d, then disable
  task automatic enable_run(input int d, input int n);
    int e;
    e = cyc;
    i_enable = 1'b1;
    for (int k = 0; k < n; k++) push_tick(e + d - 1 + k * d, k);
    wait_cyc(e + d * n);
    i_enable = 1'b0;
  endtask

  int e, e2, c0, dend, idx, cnt, exp_cnt;

  initial begin
    i_reset_n  = 1'b0;
    i_enable   = 1'b1;
    i_div_load = 1'b1;
    i_div_int  = 12'd7;
    i_div_frac = 8'd0;

    // outputs held low during reset despite enable and load
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (o_tick !== 1'b0) begin
        fails++; $display("FAIL reset_tick: got %b, required 0", o_tick);
      end
      checks++;
      if (o_bit_tick !== 1'b0) begin
        fails++; $display("FAIL reset_bit_tick: got %b, required 0", o_bit_tick);
      end
      checks++;
      if (o_load_ack !== 1'b0) begin
        fails++; $display("FAIL reset_ack: got %b, required 0", o_load_ack);
      end
    end

    // default divisor 162: first tick 162 cycles after enable
    i_reset_n  = 1'b1;
    i_div_load = 1'b0;
    e = cyc;
    push_tick(e + 161, 0);
    wait_cyc(e + 162);
    i_enable = 1'b0;

    // div 4, frac 0: tick every 4, bit tick every 64
    wait_cyc(cyc + 1);
    aq.push_back(cyc);
    do_load(4, 0);
    enable_run(4, 40);

    // load mid-period, then load coincident with a tick
    wait_cyc(cyc + 2);
    e = cyc;
    i_enable = 1'b1;
    push_tick(e + 3, 0);
    push_tick(e + 7, 1);
    wait_cyc(e + 5);
    aq.push_back(e + 7);
    do_load(10, 0);
    push_tick(e + 17, 2);
    push_tick(e + 27, 3);
    wait_cyc(e + 27);
    aq.push_back(e + 27);
    do_load(4, 0);
    push_tick(e + 31, 4);
    push_tick(e + 35, 5);
    wait_cyc(e + 36);
    i_enable = 1'b0;

    // div 0 clamps to 2
    wait_cyc(cyc + 1);
    aq.push_back(cyc);
    do_load(0, 0);
    enable_run(2, 20);

    // two loads before a tick: last one wins, single ack
    wait_cyc(cyc + 1);
    aq.push_back(cyc);
    do_load(8, 0);
    e = cyc;
    i_enable = 1'b1;
    push_tick(e + 7, 0);
    wait_cyc(e + 1);
    do_load(3, 0);
    wait_cyc(e + 3);
    aq.push_back(e + 7);
    do_load(5, 0);
    push_tick(e + 12, 1);
    push_tick(e + 17, 2);
    wait_cyc(e + 18);
    i_enable = 1'b0;

    // drop enable in a would-be tick cycle, then re-enable: os restarts
    wait_cyc(cyc + 2);
    e = cyc;
    i_enable = 1'b1;
    for (int k = 0; k < 18; k++) push_tick(e + 4 + 5 * k, k);
    wait_cyc(e + 94);
    i_enable = 1'b0;
    wait_cyc(e + 104);
    enable_run(5, 16);

    // fractional divisor 4 + 128/256
    wait_cyc(cyc + 1);
    aq.push_back(cyc);
    do_load(4, 128);
    e = cyc;
    dend = e + 7208;
    i_enable = 1'b1;
`ifdef BAUD_GEN_FRAC_EN
    push_tick(e + 3, 0);
    push_tick(e + 7, 1);
    idx = 2;
    for (int m = 0; m < 801; m++) begin
      if (e + 12 + 9 * m < dend) begin push_tick(e + 12 + 9 * m, idx); idx++; end
      if (e + 16 + 9 * m < dend) begin push_tick(e + 16 + 9 * m, idx); idx++; end
    end
    exp_cnt = 1600;
`else
    idx = 0;
    while (e + 3 + 4 * idx < dend) begin
      push_tick(e + 3 + 4 * idx, idx);
      idx++;
    end
    exp_cnt = 1800;
`endif
    wait_cyc(e + 8);
    c0 = tick_cnt;
    wait_cyc(dend);
    i_enable = 1'b0;
    cnt = tick_cnt - c0;
    checks++;
    if (cnt != exp_cnt) begin
      fails++; $display("FAIL tick_count_7200: got %0d, required %0d", cnt, exp_cnt);
    end

    // reset with a load pending: no ack, defaults restored
    wait_cyc(cyc + 2);
    e = cyc;
    i_enable = 1'b1;
    push_tick(e + 3, 0);
    wait_cyc(e + 4);
    do_load(20, 0);
    i_reset_n = 1'b0;
    wait_cyc(e + 6);
    i_reset_n = 1'b1;
    e2 = cyc;
    push_tick(e2 + 161, 0);
    wait_cyc(e2 + 162);
    i_enable = 1'b0;
    wait_cyc(cyc + 5);

    checks++;
    if (tq.size() != 0) begin
      fails++; $display("FAIL tick_queue_drained: got %0d left, required 0", tq.size());
    end
    checks++;
    if (aq.size() != 0) begin
      fails++; $display("FAIL ack_queue_drained: got %0d left, required 0", aq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
